// File: rtl/mac_st_sequencer_pkg.sv
// Shared encodings, state type and width helpers for the Sum-Together MAC job sequencer.
package mac_st_pkg;

   // MAC operating modes as seen on config_aw
   localparam logic [1:0] CFG_8X8 = 2'b00;
   localparam logic [1:0] CFG_4X4 = 2'b01;
   localparam logic [1:0] CFG_2X2 = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      HOLD
   } state_t;

   // Width of the MAC z output: 16-bit products plus accumulator headroom
   function automatic int unsigned z_width(input int unsigned headroom);
      return 16 + headroom;
   endfunction

   // The MAC has no meaning for 2'b10; fold it onto the 2x2 mode
   function automatic logic [1:0] legal_cfg(input logic [1:0] cfg);
      logic [1:0] res;
      unique case (cfg)
         CFG_8X8: res = CFG_8X8;
         CFG_4X4: res = CFG_4X4;
         default: res = CFG_2X2;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mac_st_sequencer_if.sv
// Job, operand, MAC and result signals between the sequencer and its environment.
interface mac_st_sequencer_if
   import mac_st_pkg::*;
#(
   parameter int unsigned HEADROOM = 4,
   parameter int unsigned LEN_W    = 8
);

   localparam int unsigned ZW = z_width(HEADROOM);

   // job request
   logic             start;
   logic [1:0]       cfg_aw;
   logic [LEN_W-1:0] len;
   logic             busy;

   // operand stream
   logic             op_valid;
   logic [7:0]       op_a;
   logic [7:0]       op_w;
   logic             op_ready;

   // MAC side
   logic [7:0]       mac_a;
   logic [7:0]       mac_w;
   logic             mac_accu_rst;
   logic [1:0]       mac_config_aw;
   logic [ZW-1:0]    mac_z;

   // result
   logic             res_valid;
   logic [ZW-1:0]    res_data;
   logic             res_ready;

   // sequencer side
   modport master (
      input  start, cfg_aw, len, op_valid, op_a, op_w, mac_z, res_ready,
      output busy, op_ready, mac_a, mac_w, mac_accu_rst, mac_config_aw, res_valid, res_data
   );

   // job source, operand source, MAC and result consumer side
   modport slave (
      output start, cfg_aw, len, op_valid, op_a, op_w, mac_z, res_ready,
      input  busy, op_ready, mac_a, mac_w, mac_accu_rst, mac_config_aw, res_valid, res_data
   );

endinterface

// File: rtl/mac_st_sequencer.sv
// Runs one dot-product job on the Sum-Together MAC: clear, stream operands, drain, return z.
module mac_st_sequencer
   import mac_st_pkg::*;
#(
   parameter int unsigned HEADROOM = 4,
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned MAC_LAT  = 2
) (
   input logic                clk,
   input logic                rst,
   mac_st_sequencer_if.master bus
);

   localparam int unsigned ZW = z_width(HEADROOM);
   localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   state_t           state_q, state_d;
   logic [1:0]       cfg_q, cfg_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] beat_q, beat_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [ZW-1:0]    res_q, res_d;

   logic             beat_acc;
   logic             last_beat;
   logic             last_drain;

   assign beat_acc   = (state_q == STREAM) && bus.op_valid;
   // one extra bit so len = all-ones completes without the compare wrapping
   assign last_beat  = (({1'b0, beat_q} + (LEN_W+1)'(1)) == {1'b0, len_q});
   assign last_drain = (drain_q == DW'(MAC_LAT - 1));

   // state and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cfg_q   <= CFG_8X8;
         len_q   <= '0;
         beat_q  <= '0;
         drain_q <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         drain_q <= drain_d;
         res_q   <= res_d;
      end
   end

   // next-state, job latching, beat/drain counting and z capture
   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      len_d   = len_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               cfg_d   = legal_cfg(bus.cfg_aw);
               len_d   = bus.len;
               beat_d  = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            drain_d = '0;
            state_d = (len_q != '0) ? STREAM : DRAIN;
         end
         STREAM: begin
            if (beat_acc) begin
               beat_d = beat_q + LEN_W'(1);
               if (last_beat) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (last_drain) begin
               res_d   = bus.mac_z;
               drain_d = '0;
               state_d = HOLD;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         HOLD: begin
            if (bus.res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // output decode; operands pass straight through so stall bubbles feed zero products
   always_comb begin
      bus.busy          = (state_q != IDLE);
      bus.op_ready      = (state_q == STREAM);
      bus.mac_a         = beat_acc ? bus.op_a : 8'h00;
      bus.mac_w         = beat_acc ? bus.op_w : 8'h00;
      bus.mac_accu_rst  = (state_q == CLEAR);
      bus.mac_config_aw = cfg_q;
      bus.res_valid     = (state_q == HOLD);
      bus.res_data      = res_q;
   end

endmodule

// File: tb/tb_mac_st_sequencer.sv
// Self-checking bench for mac_st_sequencer with a behavioural Sum-Together MAC alongside.
module tb_mac_st_sequencer;
   import mac_st_pkg::*;

   localparam int unsigned HEADROOM = 4;
   localparam int unsigned LEN_W    = 8;
   localparam int unsigned MAC_LAT  = 2;
   localparam int unsigned ZW       = 16 + HEADROOM;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   int n_checks = 0;
   int n_fail   = 0;
   int n_clr    = 0;
   int n_rdy    = 0;

   logic [ZW-1:0] exp_q[$];
   logic [1:0]    exp_cfg = 2'b00;

   mac_st_sequencer_if #(.HEADROOM(HEADROOM), .LEN_W(LEN_W)) bus ();

   mac_st_sequencer #(
      .HEADROOM (HEADROOM),
      .LEN_W    (LEN_W),
      .MAC_LAT  (MAC_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Sum-Together product: unsigned activation sub-words times signed weight sub-words
   function automatic logic signed [ZW-1:0] prod(input logic [7:0] a, input logic [7:0] w,
                                                 input logic [1:0] cfg);
      logic signed [ZW-1:0] s;
      s = '0;
      case (cfg)
         2'b00: s = $signed({1'b0, a}) * $signed(w);
         2'b01: for (int i = 0; i < 2; i++)
                   s = s + $signed({1'b0, a[4*i +: 4]}) * $signed(w[4*i +: 4]);
         default: for (int i = 0; i < 4; i++)
                   s = s + $signed({1'b0, a[2*i +: 2]}) * $signed(w[2*i +: 2]);
      endcase
      return s;
   endfunction

   // MAC model: input register then accumulator register (two cycles of latency)
   logic [7:0]           ma_q   = '0;
   logic [7:0]           mw_q   = '0;
   logic                 mrst_q = 1'b0;
   logic signed [ZW-1:0] acc_q  = '0;
   always @(posedge clk) begin
      ma_q   <= bus.mac_a;
      mw_q   <= bus.mac_w;
      mrst_q <= bus.mac_accu_rst;
      if (mrst_q) acc_q <= '0;
      else        acc_q <= acc_q + prod(ma_q, mw_q, bus.mac_config_aw);
   end
   assign bus.mac_z = acc_q;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // result scoreboard, pulse counters and mode-hold watch
   always @(negedge clk) begin
      if (!rst && bus.res_valid && bus.res_ready) begin
         if (exp_q.size() == 0) check_eq("res_unexpected", 32'd1, 32'd0);
         else check_eq("res_data", 32'(bus.res_data), 32'(exp_q.pop_front()));
      end
      if (bus.mac_accu_rst) n_clr++;
      if (bus.op_ready) n_rdy++;
      if (bus.busy) check_eq("cfg_hold", 32'(bus.mac_config_aw), 32'(exp_cfg));
   end

   // Drive one job; returns in the handshake-complete IDLE cycle, or in the first HOLD
   // cycle when res_ready is low.
   task automatic run_job(input logic [1:0] cfg, input logic [7:0] n, input logic [7:0] av[8],
                          input logic [7:0] wv[8], input int gap, input logic [1:0] cfg_exp,
                          input logic [ZW-1:0] z_exp, input bit toggle);
      int  clr0, lcyc;
      bit  seen;
      exp_q.push_back(z_exp);
      exp_cfg = cfg_exp;
      clr0    = n_clr;
      step();
      bus.start  = 1'b1;
      bus.cfg_aw = cfg;
      bus.len    = n;
      bus.op_valid = 1'b0;
      step();
      bus.start = 1'b0;
      if (toggle) bus.cfg_aw = ~bus.cfg_aw;
      @(negedge clk);
      check_eq("clear_rst", 32'(bus.mac_accu_rst), 32'd1);
      check_eq("clear_a", 32'(bus.mac_a), 32'd0);
      lcyc = cyc;
      for (int b = 0; b < int'(n); b++) begin
         for (int g = 0; g < gap; g++) begin
            step();
            if (toggle) bus.cfg_aw = ~bus.cfg_aw;
            bus.op_valid = 1'b0;
            bus.op_a = 8'($urandom);
            bus.op_w = 8'($urandom) | 8'h01;
            @(negedge clk);
            check_eq("gap_a", 32'(bus.mac_a), 32'd0);
            check_eq("gap_w", 32'(bus.mac_w), 32'd0);
            check_eq("gap_ready", 32'(bus.op_ready), 32'd1);
         end
         step();
         if (toggle) bus.cfg_aw = ~bus.cfg_aw;
         bus.op_valid = 1'b1;
         bus.op_a = av[b];
         bus.op_w = wv[b];
         @(negedge clk);
         check_eq("beat_a", 32'(bus.mac_a), 32'(av[b]));
         lcyc = cyc;
      end
      // junk operands are offered while draining; nothing may reach the MAC
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step();
         if (toggle) bus.cfg_aw = ~bus.cfg_aw;
         bus.op_valid = 1'b1;
         bus.op_a = 8'hA5;
         bus.op_w = 8'h5A;
         @(negedge clk);
         if (bus.res_valid) seen = 1'b1;
         else begin
            check_eq("drain_ready", 32'(bus.op_ready), 32'd0);
            check_eq("drain_a", 32'(bus.mac_a), 32'd0);
         end
      end
      bus.op_valid = 1'b0;
      check_eq("res_timeout", 32'(seen), 32'd1);
      check_eq("latency", 32'(cyc - lcyc), 32'(MAC_LAT + 1));
      check_eq("clr_pulses", 32'(n_clr - clr0), 32'd1);
      if (bus.res_ready) begin
         step();
         @(negedge clk);
         check_eq("idle_after", 32'(bus.busy), 32'd0);
      end
   endtask

   initial begin
      logic [7:0]    av[8];
      logic [7:0]    wv[8];
      logic [ZW-1:0] z5;
      int            rdy0;

      rst = 1'b1;
      bus.start = 1'b0; bus.cfg_aw = 2'b00; bus.len = '0;
      bus.op_valid = 1'b0; bus.op_a = '0; bus.op_w = '0;
      bus.res_ready = 1'b1;
      av = '{default: 8'h00};
      wv = '{default: 8'h00};
      repeat (2) step();
      @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_ready", 32'(bus.op_ready), 32'd0);
      check_eq("rst_valid", 32'(bus.res_valid), 32'd0);
      check_eq("rst_clr", 32'(bus.mac_accu_rst), 32'd0);
      check_eq("rst_cfg", 32'(bus.mac_config_aw), 32'd0);
      check_eq("rst_data", 32'(bus.res_data), 32'd0);
      step();
      rst = 1'b0;

      // 1: 8x8 back-to-back, 30 - 10 + 1
      av[0] = 8'd10; wv[0] = 8'd3;
      av[1] = 8'd5;  wv[1] = 8'hFE;
      av[2] = 8'd1;  wv[2] = 8'd1;
      run_job(2'b00, 8'd3, av, wv, 0, 2'b00, ZW'(21), 1'b0);

      // 2: same job with two-cycle stalls
      run_job(2'b00, 8'd3, av, wv, 2, 2'b00, ZW'(21), 1'b0);

      // 3: empty job, ready never raised
      rdy0 = n_rdy;
      run_job(2'b00, 8'd0, av, wv, 0, 2'b00, ZW'(0), 1'b0);
      check_eq("len0_ready", 32'(n_rdy - rdy0), 32'd0);

      // 4: backpressure, start during HOLD and on the handshake cycle is ignored
      bus.res_ready = 1'b0;
      run_job(2'b00, 8'd3, av, wv, 0, 2'b00, ZW'(21), 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         bus.start = (i == 2);
         @(negedge clk);
         check_eq("hold_data", 32'(bus.res_data), 32'd21);
         check_eq("hold_busy", 32'(bus.busy), 32'd1);
      end
      step();
      bus.start = 1'b1;
      bus.res_ready = 1'b1;
      step();
      bus.start = 1'b0;
      @(negedge clk);
      check_eq("hold_release", 32'(bus.busy), 32'd0);
      step();
      @(negedge clk);
      check_eq("no_restart", 32'(bus.busy), 32'd0);

      // 5: 2x2 mode held while cfg_aw input toggles; then 10 folds onto 11
      av[0] = 8'h1B; wv[0] = 8'hC9;
      av[1] = 8'hE4; wv[1] = 8'h7F;
      av[2] = 8'hFF; wv[2] = 8'h80;
      av[3] = 8'h36; wv[3] = 8'h55;
      z5 = '0;
      for (int i = 0; i < 4; i++) z5 = z5 + prod(av[i], wv[i], 2'b11);
      run_job(2'b11, 8'd4, av, wv, 0, 2'b11, z5, 1'b1);
      run_job(2'b10, 8'd4, av, wv, 1, 2'b11, z5, 1'b1);

      // 6: reset after 2 of 5 beats, then a fresh 4x4 job
      exp_cfg = 2'b00;
      step();
      bus.start = 1'b1; bus.cfg_aw = 2'b00; bus.len = 8'd5;
      step();
      bus.start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         step();
         bus.op_valid = 1'b1; bus.op_a = 8'd7; bus.op_w = 8'd9;
      end
      step();
      bus.op_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      check_eq("abort_ready", 32'(bus.op_ready), 32'd0);
      check_eq("abort_valid", 32'(bus.res_valid), 32'd0);
      check_eq("abort_cfg", 32'(bus.mac_config_aw), 32'd0);
      check_eq("abort_data", 32'(bus.res_data), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         check_eq("abort_novalid", 32'(bus.res_valid), 32'd0);
      end
      av[0] = 8'h11; wv[0] = 8'h11;
      run_job(2'b01, 8'd1, av, wv, 0, 2'b01, ZW'(2), 1'b0);

      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
